// File: rtl/mul15_product_accumulator.sv
// Sums ACC_LEN consecutive 30-bit products from the 15x15 multiplier into one
// ACC_W-bit result, saturating on overflow, and presents it on a valid/ready port.
module mul15_product_accumulator #(
  parameter  int ACC_LEN = 16,
  parameter  int ACC_W   = 34,
  localparam int CNT_W   = $clog2(ACC_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [29:0]      p_in,
  input  logic             p_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             sat,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ACC_LEN);

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_pend_q;
  logic               sat_q;
  logic               vld_q;

  logic [ACC_W:0]     add_w;
  logic [ACC_W-1:0]   acc_d;
  logic               ovf_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               last_beat;

  // Returns {overflow, value}; on carry-out the value clamps to all-ones, so a
  // saturated accumulator stays saturated for the rest of the run.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [29:0]      b);
    logic [ACC_W:0] wide;
    wide = {1'b0, a} + {{(ACC_W + 1 - 30){1'b0}}, b};
    if (wide[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = wide;
    end
  endfunction

  always_comb begin
    add_w     = sat_add(acc_q, p_in);
    acc_d     = add_w[ACC_W-1:0];
    ovf_d     = add_w[ACC_W];
    cnt_d     = cnt_q + CNT_W'(1);
    last_beat = (cnt_q == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      sat_pend_q <= 1'b0;
      sat_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else if (clear) begin
      // Abort: drop any partial sum or unconsumed result; sum_q keeps its value.
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_pend_q <= 1'b0;
      sat_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (p_valid) begin
            acc_q <= acc_d;
            if (last_beat) begin
              sum_q      <= acc_d;
              sat_q      <= sat_pend_q | ovf_d;
              sat_pend_q <= 1'b0;
              vld_q      <= 1'b1;
              cnt_q      <= FULL_CNT;
              state_q    <= S_HOLD;
            end else begin
              sat_pend_q <= sat_pend_q | ovf_d;
              cnt_q      <= cnt_d;
              state_q    <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (sum_ready) begin
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q != S_HOLD);
  assign sum_out   = sum_q;
  assign sum_valid = vld_q;
  assign sat       = sat_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_mul15_product_accumulator.sv
// Directed bench for mul15_product_accumulator: default instance plus a narrow
// (ACC_W=31) instance sharing the same stimulus to exercise saturation.
module tb_mul15_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, en, clear, p_valid, sum_ready;
  logic [29:0] p_in;

  logic        in_ready0, sum_valid0, sat0;
  logic [33:0] sum_out0;
  logic [4:0]  beat_cnt0;
  logic        in_ready1, sum_valid1, sat1;
  logic [30:0] sum_out1;
  logic [4:0]  beat_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul15_product_accumulator #(.ACC_LEN(16), .ACC_W(34)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .p_in(p_in),
    .p_valid(p_valid), .in_ready(in_ready0), .sum_out(sum_out0),
    .sum_valid(sum_valid0), .sum_ready(sum_ready), .sat(sat0),
    .beat_cnt(beat_cnt0)
  );

  mul15_product_accumulator #(.ACC_LEN(16), .ACC_W(31)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .p_in(p_in),
    .p_valid(p_valid), .in_ready(in_ready1), .sum_out(sum_out1),
    .sum_valid(sum_valid1), .sum_ready(sum_ready), .sat(sat1),
    .beat_cnt(beat_cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [29:0] v);
    for (int i = 0; i < n; i++) begin
      p_valid = 1'b1;
      p_in    = v;
      step();
    end
    p_valid = 1'b0;
  endtask

  task automatic handoff();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  initial begin
    logic [33:0] held;
    longint      expq[$];
    longint      run;
    longint      exp_sum;
    logic [29:0] prod;
    int          cnt, got, cyc, a, b, idx;

    rst_n = 1'b0; en = 1'b1; clear = 1'b0; p_valid = 1'b0;
    sum_ready = 1'b0; p_in = '0;
    step(); step();
    rst_n = 1'b1;
    check("rst_sum_valid", 64'(sum_valid0), 64'd0);
    check("rst_beat_cnt",  64'(beat_cnt0),  64'd0);
    check("rst_in_ready",  64'(in_ready0),  64'd1);
    check("rst_sum_out",   64'(sum_out0),   64'd0);
    check("rst_sat",       64'(sat0),       64'd0);

    // Reset in the middle of an accumulation
    feed(5, 30'd1);
    check("mid_beat_cnt", 64'(beat_cnt0), 64'd5);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("midrst_beat_cnt",  64'(beat_cnt0),  64'd0);
    check("midrst_sum_valid", 64'(sum_valid0), 64'd0);
    check("midrst_in_ready",  64'(in_ready0),  64'd1);
    feed(15, 30'd1);
    check("ones_not_yet_valid", 64'(sum_valid0), 64'd0);
    check("ones_cnt15",         64'(beat_cnt0),  64'd15);
    feed(1, 30'd1);
    check("ones_valid",    64'(sum_valid0), 64'd1);
    check("ones_sum",      64'(sum_out0),   64'd16);
    check("ones_in_ready", 64'(in_ready0),  64'd0);
    check("ones_cnt16",    64'(beat_cnt0),  64'd16);
    check("ones_sat",      64'(sat0),       64'd0);
    handoff();
    check("ho_valid",    64'(sum_valid0), 64'd0);
    check("ho_in_ready", 64'(in_ready0),  64'd1);
    check("ho_cnt",      64'(beat_cnt0),  64'd0);
    check("ho_sum_kept", 64'(sum_out0),   64'd16);

    // Max operands; the narrow instance saturates on the third beat
    feed(16, 30'd1073676289);
    check("max_valid",     64'(sum_valid0), 64'd1);
    check("max_sum",       64'(sum_out0),   64'd17178820624);
    check("max_sat",       64'(sat0),       64'd0);
    check("max_in_ready",  64'(in_ready0),  64'd0);
    check("nar_sum",       64'(sum_out1),   64'd2147483647);
    check("nar_sat",       64'(sat1),       64'd1);

    // Backpressure with p_valid held high
    held = sum_out0;
    p_valid = 1'b1; p_in = 30'd5; sum_ready = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("bp_sum_stable", 64'(sum_out0),   64'(held));
    check("bp_cnt",        64'(beat_cnt0),  64'd16);
    check("bp_valid",      64'(sum_valid0), 64'd1);
    check("bp_in_ready",   64'(in_ready0),  64'd0);
    sum_ready = 1'b1;
    step();
    check("bp_ho_valid",    64'(sum_valid0), 64'd0);
    check("bp_ho_cnt",      64'(beat_cnt0),  64'd0);
    check("bp_ho_in_ready", 64'(in_ready0),  64'd1);
    check("nar_ho_sat",     64'(sat1),       64'd0);
    sum_ready = 1'b0;
    step();
    check("bp_first_beat", 64'(beat_cnt0), 64'd1);
    feed(15, 30'd5);
    check("fives_sum",     64'(sum_out0), 64'd80);
    check("nar_fives_sum", 64'(sum_out1), 64'd80);
    check("nar_fives_sat", 64'(sat1),     64'd0);
    handoff();

    // en gaps: every third cycle has en low
    idx = 0; cyc = 0;
    while (idx < 16) begin
      en = (cyc % 3) != 2;
      p_valid = 1'b1;
      p_in = 30'(idx);
      if (idx == 15 && en) check("gap_pre_valid", 64'(sum_valid0), 64'd0);
      step();
      if (en) idx++;
      cyc++;
    end
    p_valid = 1'b0; en = 1'b1;
    check("gap_valid", 64'(sum_valid0), 64'd1);
    check("gap_sum",   64'(sum_out0),   64'd120);
    en = 1'b0; sum_ready = 1'b1;
    step();
    check("en0_hold_valid", 64'(sum_valid0), 64'd1);
    en = 1'b1;
    step();
    sum_ready = 1'b0;
    check("en1_ho_valid", 64'(sum_valid0), 64'd0);

    // clear mid-accumulation, with a beat offered in the same cycle
    feed(5, 30'd7);
    clear = 1'b1; p_valid = 1'b1; p_in = 30'd100;
    step();
    clear = 1'b0; p_valid = 1'b0;
    check("clr_acc_cnt",   64'(beat_cnt0),  64'd0);
    check("clr_acc_valid", 64'(sum_valid0), 64'd0);
    feed(16, 30'd2);
    check("clr_acc_fresh", 64'(sum_out0), 64'd32);
    // clear while holding an unconsumed result
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_hold_valid",    64'(sum_valid0), 64'd0);
    check("clr_hold_cnt",      64'(beat_cnt0),  64'd0);
    check("clr_hold_in_ready", 64'(in_ready0),  64'd1);
    feed(16, 30'd4);
    check("clr_hold_fresh", 64'(sum_out0), 64'd64);
    check("clr_hold_nvld",  64'(sum_valid0), 64'd1);
    handoff();

    // Random sweep against a running-sum model with random backpressure
    run = 0; cnt = 0; got = 0; cyc = 0;
    while (got < 50 && cyc < 40000) begin
      a = int'($urandom_range(0, 32767));
      b = int'($urandom_range(0, 32767));
      prod = 30'(a * b);
      p_in = prod;
      p_valid = ($urandom_range(0, 3) != 0);
      sum_ready = $urandom_range(0, 1) == 1;
      if (sum_valid0 && sum_ready) begin
        if (expq.size() == 0) begin
          check("sweep_extra_result", 64'd1, 64'd0);
        end else begin
          exp_sum = expq.pop_front();
          check("sweep_sum", 64'(sum_out0), 64'(exp_sum));
        end
        got++;
      end
      if (p_valid && in_ready0) begin
        run += longint'(prod);
        cnt++;
        if (cnt == 16) begin
          expq.push_back(run);
          run = 0;
          cnt = 0;
        end
      end
      step();
      cyc++;
    end
    p_valid = 1'b0; sum_ready = 1'b0;
    check("sweep_results", 64'(got), 64'd50);
    check("sweep_pending", 64'(expq.size() > 1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
